// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle for sync_fifo_param.
// The producer/consumer side uses the master modport; the FIFO uses slave.
interface sync_fifo_param_if #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [FIFO_WIDTH-1:0] data_in;
    logic                  wr_en;
    logic                  rd_en;
    logic [FIFO_WIDTH-1:0] data_out;
    logic                  rd_valid;
    logic                  wr_ack;
    logic                  overflow;
    logic                  underflow;
    logic                  full;
    logic                  empty;
    logic                  almostfull;
    logic                  almostempty;
    logic [CW-1:0]         count;

    modport master (
        output data_in, wr_en, rd_en,
        input  data_out, rd_valid, wr_ack, overflow, underflow,
        input  full, empty, almostfull, almostempty, count
    );

    modport slave (
        input  data_in, wr_en, rd_en,
        output data_out, rd_valid, wr_ack, overflow, underflow,
        output full, empty, almostfull, almostempty, count
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with arbitrary (non power-of-two) depth,
// almost-full/almost-empty thresholds, occupancy count and an optional
// first-word-fall-through read port. Flags decode only the count register,
// so there is no combinational path from wr_en/rd_en to any flag.
module sync_fifo_param #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_MARGIN  = 1,
    parameter int AE_MARGIN  = 1,
    parameter bit FWFT       = 1'b0
) (
    input logic              clk,
    input logic              rst,
    sync_fifo_param_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF_LEVEL = CW'(FIFO_DEPTH - AF_MARGIN);
    localparam logic [CW-1:0] AE_LEVEL = CW'(AE_MARGIN);
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

    // Storage is deliberately left without reset; occupancy alone defines
    // which entries are meaningful.
    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr_inc;
    logic [PW-1:0] rd_ptr_inc;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;

    logic is_full;
    logic is_empty;
    logic wr_ok;
    logic rd_ok;

    // Occupancy flags, decoded from the registered count only.
    assign is_full  = (count == DEPTH_C);
    assign is_empty = (count == '0);

    // Accept rules: a read needs data; a write needs space, or a read
    // leaving this same cycle to free a slot. An empty FIFO rejects the
    // read even when a write arrives alongside it.
    assign rd_ok = bus.rd_en && !is_empty;
    assign wr_ok = bus.wr_en && (!is_full || rd_ok);

    // Pointers wrap by explicit compare so any depth works.
    assign wr_ptr_inc = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
    assign rd_ptr_inc = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);

    // Net occupancy change for this cycle.
    always_comb begin
        count_next = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr_inc;
            if (rd_ok) rd_ptr <= rd_ptr_inc;
            count <= count_next;
        end
    end

    // Storage write. When full with a simultaneous pop, wr_ptr equals
    // rd_ptr; the read below samples the old word before it is replaced.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= bus.data_in;
    end

    // Single-cycle status pulses describing the previous cycle's requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.wr_ack    <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b0;
        end else begin
            bus.wr_ack    <= wr_ok;
            bus.overflow  <= bus.wr_en && !wr_ok;
            bus.underflow <= bus.rd_en && !rd_ok;
        end
    end

    assign bus.full        = is_full;
    assign bus.empty       = is_empty;
    assign bus.almostfull  = (count >= AF_LEVEL) && !is_full;
    assign bus.almostempty = !is_empty && (count <= AE_LEVEL);
    assign bus.count       = count;

    generate
        if (FWFT == 1'b0) begin : g_std
            logic [FIFO_WIDTH-1:0] dout_q;
            logic                  vld_q;

            // Registered read: data lands one cycle after the accepted pop
            // and holds until the next one.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout_q <= '0;
                    vld_q  <= 1'b0;
                end else begin
                    vld_q <= rd_ok;
                    if (rd_ok) dout_q <= mem[rd_ptr];
                end
            end

            assign bus.data_out = dout_q;
            assign bus.rd_valid = vld_q;
        end else begin : g_fwft
            // Head of queue is always presented; masking with empty keeps the
            // unreset storage off data_out after reset or when drained.
            assign bus.data_out = is_empty ? '0 : mem[rd_ptr];
            assign bus.rd_valid = !is_empty;
        end
    endgenerate
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a standard-read instance and an FWFT
// instance, both depth 5, checked against a queue model and a scoreboard of
// expected read words.
module tb_sync_fifo_param;
    localparam int W = 16;
    localparam int D = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sync_fifo_param_if #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) bus0 ();
    sync_fifo_param_if #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) bus1 ();

    sync_fifo_param #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .AF_MARGIN(1),
                      .AE_MARGIN(1), .FWFT(1'b0))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));

    sync_fifo_param #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .AF_MARGIN(1),
                      .AE_MARGIN(1), .FWFT(1'b1))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] model0 [$];
    logic [W-1:0] model1 [$];
    logic [W-1:0] exp_q  [$];
    logic [W-1:0] last_dout = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string p, input int n, input logic [2:0] cnt,
                             input logic f, input logic e, input logic af, input logic ae);
        chk({p, "count"},       32'(cnt), 32'(n));
        chk({p, "full"},        32'(f),   32'(n == D));
        chk({p, "empty"},       32'(e),   32'(n == 0));
        chk({p, "almostfull"},  32'(af),  32'(n >= D - 1 && n < D));
        chk({p, "almostempty"}, 32'(ae),  32'(n > 0 && n <= 1));
    endtask

    // One clock of traffic into the standard-read instance.
    task automatic cycle0(input bit we, input bit re, input logic [W-1:0] d);
        int n;
        bit wok, rok;
        n   = model0.size();
        rok = re && (n != 0);
        wok = we && ((n != D) || rok);
        bus0.wr_en = we; bus0.rd_en = re; bus0.data_in = d;
        if (rok) exp_q.push_back(model0.pop_front());
        if (wok) model0.push_back(d);
        @(posedge clk); #1;
        bus0.wr_en = 1'b0; bus0.rd_en = 1'b0;
        chk("s0.wr_ack",    32'(bus0.wr_ack),    32'(wok));
        chk("s0.overflow",  32'(bus0.overflow),  32'(we && !wok));
        chk("s0.underflow", 32'(bus0.underflow), 32'(re && !rok));
        chk_flags("s0.", model0.size(), bus0.count, bus0.full, bus0.empty,
                  bus0.almostfull, bus0.almostempty);
        chk("s0.rd_valid",  32'(bus0.rd_valid),  32'(rok));
        if (rok) last_dout = exp_q.pop_front();
        chk("s0.data_out",  32'(bus0.data_out),  32'(last_dout));
    endtask

    // One clock of traffic into the FWFT instance.
    task automatic cycle1(input bit we, input bit re, input logic [W-1:0] d);
        int n;
        bit wok, rok;
        n   = model1.size();
        rok = re && (n != 0);
        wok = we && ((n != D) || rok);
        bus1.wr_en = we; bus1.rd_en = re; bus1.data_in = d;
        if (rok) void'(model1.pop_front());
        if (wok) model1.push_back(d);
        @(posedge clk); #1;
        bus1.wr_en = 1'b0; bus1.rd_en = 1'b0;
        chk("f1.wr_ack",    32'(bus1.wr_ack),    32'(wok));
        chk("f1.overflow",  32'(bus1.overflow),  32'(we && !wok));
        chk("f1.underflow", 32'(bus1.underflow), 32'(re && !rok));
        chk_flags("f1.", model1.size(), bus1.count, bus1.full, bus1.empty,
                  bus1.almostfull, bus1.almostempty);
        chk("f1.rd_valid",  32'(bus1.rd_valid),  32'(model1.size() != 0));
        chk("f1.data_out",  32'(bus1.data_out),
            (model1.size() != 0) ? 32'(model1[0]) : 32'd0);
    endtask

    task automatic chk_reset();
        chk("rst.count",     32'(bus0.count),       32'd0);
        chk("rst.empty",     32'(bus0.empty),       32'd1);
        chk("rst.full",      32'(bus0.full),        32'd0);
        chk("rst.af",        32'(bus0.almostfull),  32'd0);
        chk("rst.ae",        32'(bus0.almostempty), 32'd0);
        chk("rst.data_out",  32'(bus0.data_out),    32'd0);
        chk("rst.rd_valid",  32'(bus0.rd_valid),    32'd0);
        chk("rst.wr_ack",    32'(bus0.wr_ack),      32'd0);
        chk("rst.overflow",  32'(bus0.overflow),    32'd0);
        chk("rst.underflow", 32'(bus0.underflow),   32'd0);
        chk("rst.f1_count",  32'(bus1.count),       32'd0);
        chk("rst.f1_valid",  32'(bus1.rd_valid),    32'd0);
        chk("rst.f1_dout",   32'(bus1.data_out),    32'd0);
    endtask

    initial begin
        bus0.wr_en = 1'b0; bus0.rd_en = 1'b0; bus0.data_in = '0;
        bus1.wr_en = 1'b0; bus1.rd_en = 1'b0; bus1.data_in = '0;

        // Power-up reset.
        repeat (2) @(posedge clk);
        #1;
        chk_reset();
        rst = 1'b0;

        // Fill 1..5, then one write too many.
        for (int i = 1; i <= D; i++) cycle0(1'b1, 1'b0, W'(i));
        cycle0(1'b1, 1'b0, 16'h0006);

        // Drain all five, then one read too many.
        for (int i = 0; i < D; i++) cycle0(1'b0, 1'b1, '0);
        cycle0(1'b0, 1'b1, '0);

        // Hold count at 2 while streaming across the pointer wrap.
        cycle0(1'b1, 1'b0, 16'h0100);
        cycle0(1'b1, 1'b0, 16'h0101);
        for (int i = 2; i < 14; i++) cycle0(1'b1, 1'b1, W'(16'h0100 + i));

        // Full with simultaneous read and write.
        while (model0.size() < D) cycle0(1'b1, 1'b0, W'(16'h0200 + model0.size()));
        cycle0(1'b1, 1'b1, 16'h02FF);

        // Drain, then empty with both requests asserted.
        for (int i = 0; i < D; i++) cycle0(1'b0, 1'b1, '0);
        cycle0(1'b1, 1'b1, 16'h0333);
        cycle0(1'b0, 1'b1, '0);

        // Mixed random traffic.
        for (int i = 0; i < 60; i++)
            cycle0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom));

        // FWFT: word visible the cycle after the write without rd_en.
        cycle1(1'b1, 1'b0, 16'hABCD);
        cycle1(1'b0, 1'b0, '0);
        cycle1(1'b0, 1'b1, '0);
        for (int i = 0; i < 7; i++) cycle1(1'b1, 1'b0, W'(16'h0C00 + i));
        for (int i = 0; i < 3; i++) cycle1(1'b1, 1'b1, W'(16'h0D00 + i));
        for (int i = 0; i < 6; i++) cycle1(1'b0, 1'b1, '0);

        // Mid-stream reset at count 3 with a write just acknowledged.
        while (model0.size() != 0) cycle0(1'b0, 1'b1, '0);
        cycle0(1'b1, 1'b0, 16'h0E01);
        cycle0(1'b1, 1'b0, 16'h0E02);
        cycle1(1'b1, 1'b0, 16'h0F01);
        cycle0(1'b1, 1'b0, 16'h0E03);
        rst = 1'b1;
        #2;
        chk_reset();
        #2;
        rst = 1'b0;
        model0.delete();
        model1.delete();
        exp_q.delete();
        last_dout = '0;
        cycle0(1'b0, 1'b1, '0);
        cycle0(1'b1, 1'b0, 16'h0E10);
        cycle0(1'b0, 1'b1, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
